// File: rtl/controlador_contador_ms.sv
// Millisecond counter sequencer. A prescaler divides clk into 1 ms ticks
// while counting. A 16-bit count advances on each tick until it equals the
// loaded target, then the block reports completion with a one-cycle fin pulse.
module controlador_contador_ms #(
  parameter int CICLOS_POR_MS = 100000,
  parameter int ANCHO         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iniciar,
  input  logic             pausar,
  input  logic             limpiar,
  input  logic             cargar_meta,
  input  logic [ANCHO-1:0] meta,
  output logic [ANCHO-1:0] conteo,
  output logic             tick_ms,
  output logic             fin,
  output logic [1:0]       estado,
  output logic             ocupado
);

  localparam int PW = (CICLOS_POR_MS > 1) ? $clog2(CICLOS_POR_MS) : 1;

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSA    = 2'b10,
    FIN      = 2'b11
  } estado_t;

  estado_t         est, est_n;
  logic [PW-1:0]   pre, pre_n;
  logic [ANCHO-1:0] cnt_n, tgt, tgt_n, suma;
  logic            tick_n, fin_n;
  logic            cmd_ini, cmd_pau, wrap;

  // Commands resolved by priority: limpiar > cargar_meta > iniciar > pausar.
  // A lower command is masked whenever a higher one is present, even if the
  // higher one is itself ignored in the current state.
  assign cmd_ini = iniciar & ~limpiar & ~cargar_meta;
  assign cmd_pau = pausar  & ~limpiar & ~cargar_meta & ~iniciar;
  assign wrap    = (pre == PW'(CICLOS_POR_MS - 1));
  assign suma    = conteo + 1'b1;

  // State register plus datapath registers; tick_ms/fin are registered pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      est     <= REPOSO;
      pre     <= '0;
      conteo  <= '0;
      tgt     <= '0;
      tick_ms <= 1'b0;
      fin     <= 1'b0;
    end else begin
      est     <= est_n;
      pre     <= pre_n;
      conteo  <= cnt_n;
      tgt     <= tgt_n;
      tick_ms <= tick_n;
      fin     <= fin_n;
    end
  end

  // Next-state and datapath update. Counting in CONTANDO happens on every
  // edge that is not a clear, including the edge where pausar is taken, so a
  // tick coinciding with the pause is not lost. Completion beats the pause.
  always_comb begin
    est_n  = est;
    pre_n  = pre;
    cnt_n  = conteo;
    tgt_n  = tgt;
    tick_n = 1'b0;
    fin_n  = 1'b0;
    if (limpiar) begin
      est_n = REPOSO;
      pre_n = '0;
      cnt_n = '0;
    end else begin
      if (cargar_meta && (est == REPOSO || est == FIN)) tgt_n = meta;
      case (est)
        REPOSO, FIN: begin
          if (cmd_ini) begin
            pre_n = '0;
            cnt_n = '0;
            if (tgt == '0) begin
              est_n = FIN;
              fin_n = 1'b1;
            end else begin
              est_n = CONTANDO;
            end
          end
        end
        CONTANDO: begin
          if (wrap) begin
            pre_n  = '0;
            tick_n = 1'b1;
            cnt_n  = suma;
          end else begin
            pre_n = PW'(pre + 1'b1);
          end
          if (wrap && suma == tgt) begin
            cnt_n = tgt;
            est_n = FIN;
            fin_n = 1'b1;
          end else if (cmd_pau) begin
            est_n = PAUSA;
          end
        end
        PAUSA: begin
          if (cmd_ini) est_n = CONTANDO;
        end
        default: est_n = REPOSO;
      endcase
    end
  end

  assign estado  = est;
  assign ocupado = (est == CONTANDO) || (est == PAUSA);

endmodule

// File: tb/tb_controlador_contador_ms.sv
// Bench for controlador_contador_ms. A driver issues directed and random
// commands and pushes the reference model's expected outputs into a queue;
// a monitor pops one entry per cycle and compares. A second, narrow instance
// exercises the maximum-target boundary.
module tb_controlador_contador_ms;
  localparam int C = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0, iniciar = 1'b0, pausar = 1'b0, limpiar = 1'b0, cargar_meta = 1'b0;
  logic [W-1:0] meta = '0;
  logic [W-1:0] conteo;
  logic         tick_ms, fin, ocupado;
  logic [1:0]   estado;

  controlador_contador_ms #(.CICLOS_POR_MS(C), .ANCHO(W)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .pausar(pausar), .limpiar(limpiar),
    .cargar_meta(cargar_meta), .meta(meta), .conteo(conteo), .tick_ms(tick_ms),
    .fin(fin), .estado(estado), .ocupado(ocupado)
  );

  logic       rst2 = 1'b0, ini2 = 1'b0, car2 = 1'b0;
  logic [7:0] meta2 = '0, conteo2;
  logic       tick2, fin2, ocup2;
  logic [1:0] estado2;

  controlador_contador_ms #(.CICLOS_POR_MS(2), .ANCHO(8)) dut2 (
    .clk(clk), .rst_n(rst2), .iniciar(ini2), .pausar(1'b0), .limpiar(1'b0),
    .cargar_meta(car2), .meta(meta2), .conteo(conteo2), .tick_ms(tick2),
    .fin(fin2), .estado(estado2), .ocupado(ocup2)
  );

  typedef struct packed {
    logic [W-1:0] conteo;
    logic         tick;
    logic         fin;
    logic [1:0]   estado;
    logic         ocupado;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;

  // Reference model: run time is tracked as active cycles since iniciar;
  // count, ticks and completion all follow from that by arithmetic.
  localparam int S_REP = 0, S_CNT = 1, S_PAU = 2, S_FIN = 3;
  int m_st = S_REP, m_tgt = 0, m_el = 0;

  task automatic step(input logic r, i, p, l, c, input logic [W-1:0] m);
    exp_t x;
    bit run, preq, t, f;
    @(negedge clk);
    rst_n = r; iniciar = i; pausar = p; limpiar = l; cargar_meta = c; meta = m;
    t = 0; f = 0; preq = 0; run = 0;
    if (!r) begin
      m_st = S_REP; m_tgt = 0; m_el = 0;
    end else begin
      run = (m_st == S_CNT);
      if (l) begin
        m_st = S_REP; m_el = 0; run = 0;
      end else if (c) begin
        if (m_st == S_REP || m_st == S_FIN) m_tgt = int'(m);
      end else if (i) begin
        if (m_st == S_REP || m_st == S_FIN) begin
          m_el = 0; run = 0;
          if (m_tgt == 0) begin m_st = S_FIN; f = 1; end
          else m_st = S_CNT;
        end else if (m_st == S_PAU) begin
          m_st = S_CNT; run = 0;
        end
      end else if (p) begin
        if (m_st == S_CNT) preq = 1;
      end
      if (run) begin
        m_el++;
        if (m_el % C == 0) t = 1;
        if (m_el == m_tgt * C) begin m_st = S_FIN; f = 1; end
        else if (preq) m_st = S_PAU;
      end
    end
    x.conteo  = W'(m_el / C);
    x.tick    = t;
    x.fin     = f;
    x.estado  = 2'(m_st);
    x.ocupado = (m_st == S_CNT) || (m_st == S_PAU);
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, '0);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({conteo, tick_ms, fin, estado, ocupado} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got conteo=%0d tick=%b fin=%b estado=%b ocupado=%b exp conteo=%0d tick=%b fin=%b estado=%b ocupado=%b",
                 $time, conteo, tick_ms, fin, estado, ocupado, e.conteo, e.tick, e.fin, e.estado, e.ocupado);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    // basic run, target 3
    step(1, 0, 0, 0, 1, 16'd3);
    step(1, 1, 0, 0, 0, '0);
    idle(14);
    // reset mid-count at conteo=5
    step(1, 0, 0, 0, 1, 16'd10);
    step(1, 1, 0, 0, 0, '0);
    idle(21);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    idle(50);
    // pause/resume, target 2
    step(1, 0, 0, 0, 1, 16'd2);
    step(1, 1, 0, 0, 0, '0);
    idle(5);
    step(1, 0, 1, 0, 0, '0);
    idle(13);
    step(1, 1, 0, 0, 0, '0);
    idle(5);
    // zero target, then restart from FIN
    step(1, 0, 0, 0, 1, 16'd0);
    step(1, 1, 0, 0, 0, '0);
    idle(3);
    step(1, 1, 0, 0, 0, '0);
    idle(2);
    // priority: limpiar beats iniciar; cargar_meta ignored while counting
    step(1, 0, 0, 0, 1, 16'd5);
    step(1, 1, 0, 0, 0, '0);
    idle(6);
    step(1, 1, 0, 1, 0, '0);
    idle(3);
    step(1, 1, 0, 0, 0, '0);
    idle(2);
    step(1, 0, 0, 0, 1, 16'd1);
    idle(25);
    // random commands
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 14) == 0, W'($urandom_range(0, 6)));
    idle(2);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    // maximum target on the narrow instance: 0xFF ms at 2 cycles/ms
    @(negedge clk); rst2 = 1'b0;
    @(negedge clk); rst2 = 1'b1; car2 = 1'b1; meta2 = 8'hFF;
    @(negedge clk); car2 = 1'b0; ini2 = 1'b1;
    @(negedge clk); ini2 = 1'b0;
    n = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (fin2) begin n = k; break; end
    end
    chk("max_fin_latency", n, 510);
    chk("max_conteo", int'(conteo2), 255);
    chk("max_estado", int'(estado2), 3);
    @(posedge clk); #1;
    chk("max_fin_single", int'(fin2), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("max_hold_conteo", int'(conteo2), 255);
    chk("max_hold_estado", int'(estado2), 3);
    chk("max_no_tick", int'(tick2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
